// File: rtl/iter_div.sv
// iter_div: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands are reduced to magnitudes on accept. One quotient bit is produced
// per CALC cycle by a ripple-carry trial subtractor, and signs are restored in
// FIXUP. Divide-by-zero and signed overflow bypass the loop through SPECIAL.
module iter_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, SPECIAL} state_t;

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg;
   logic             rem_sel_reg;     // op[1]: 1 selects remainder
   logic             neg_quo_reg;
   logic             neg_rem_reg;
   logic             div_zero_reg;
   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] quo_reg;         // dividend magnitude shifting out / quotient shifting in
   logic [WIDTH-1:0] divisor_reg;
   logic [WIDTH-1:0] result_reg;
   logic             done_reg;

   // Request decode: magnitudes, sign handling and special-case detection
   logic             is_signed;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             is_special;
   logic             accept;

   assign is_signed  = ~op[0];
   assign a_mag      = (is_signed && a[WIDTH-1]) ? -a : a;
   assign b_mag      = (is_signed && b[WIDTH-1]) ? -b : b;
   assign is_special = (b == '0) || (is_signed && (a == MIN_NEG) && (b == '1));

   // Trial subtraction {rem, quo msb} - {0, divisor} as a (WIDTH+1)-bit
   // ripple-carry adder in subtract mode: operand inverted, carry-in = 1.
   logic             sub_en;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   sub_opnd;
   logic [WIDTH:0]   sub_x;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   carry;
   logic             no_borrow;

   assign sub_en   = 1'b1;
   assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
   assign sub_opnd = {1'b0, divisor_reg};
   assign carry[0] = sub_en;

   generate
      for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_rca
         assign sub_x[gi] = sub_opnd[gi] ^ sub_en;
         assign diff[gi]  = shifted[gi] ^ sub_x[gi] ^ carry[gi];
         if (gi < WIDTH) begin : g_carry
            assign carry[gi+1] = (shifted[gi] & sub_x[gi]) |
                                 (carry[gi] & (shifted[gi] ^ sub_x[gi]));
         end
      end
   endgenerate

   // A clear MSB means the divisor fit: no borrow, quotient bit is 1
   assign no_borrow = ~diff[WIDTH];

   // Sign-corrected quotient and remainder used in FIXUP
   logic [WIDTH-1:0] quo_fix, rem_fix;
   assign quo_fix = neg_quo_reg ? -quo_reg : quo_reg;
   assign rem_fix = neg_rem_reg ? -rem_reg : rem_reg;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic and accept strobe
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = is_special ? SPECIAL : CALC;
            end
         end
         CALC:    if (cnt_reg == LAST_ITER) state_next = FIXUP;
         FIXUP:   state_next = IDLE;
         SPECIAL: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, and result registration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg      <= '0;
         rem_sel_reg  <= 1'b0;
         neg_quo_reg  <= 1'b0;
         neg_rem_reg  <= 1'b0;
         div_zero_reg <= 1'b0;
         rem_reg      <= '0;
         quo_reg      <= '0;
         divisor_reg  <= '0;
         result_reg   <= '0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  rem_sel_reg  <= op[1];
                  neg_quo_reg  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem_reg  <= is_signed & a[WIDTH-1];
                  div_zero_reg <= (b == '0);
                  rem_reg      <= '0;
                  // Special cases need the raw dividend, not its magnitude
                  quo_reg      <= is_special ? a : a_mag;
                  divisor_reg  <= b_mag;
                  cnt_reg      <= '0;
               end
            end
            CALC: begin
               cnt_reg <= cnt_reg + CW'(1);
               rem_reg <= no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
               quo_reg <= {quo_reg[WIDTH-2:0], no_borrow};
            end
            FIXUP: begin
               result_reg <= rem_sel_reg ? rem_fix : quo_fix;
               done_reg   <= 1'b1;
               cnt_reg    <= '0;
            end
            SPECIAL: begin
               if (div_zero_reg) result_reg <= rem_sel_reg ? quo_reg : '1;
               else              result_reg <= rem_sel_reg ? '0 : quo_reg;
               done_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy   = (state_reg != IDLE);
   assign done   = done_reg;
   assign result = result_reg;

endmodule

// File: tb/tb_iter_div.sv
// tb_iter_div: directed self-checking bench for iter_div (WIDTH=32).
module tb_iter_div;

   localparam int W = 32;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   op    = 2'd0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic [1:0]   o;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] exp;
      int           lat;
   } vec_t;

   vec_t vecs[14];

   always #5 clk = ~clk;

   iter_div #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   // Issue one request, optionally pulse start again after edge poke_edge,
   // and observe done over a fixed window of 45 edges.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input int poke_edge,
                         output logic [W-1:0] res, output int lat,
                         output int ndone);
      res   = '0;
      lat   = -1;
      ndone = 0;
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; a = $urandom; b = $urandom;
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            ndone++;
            if (lat < 0) begin
               lat = k;
               res = result;
            end
         end
         if (k == poke_edge) begin
            start = 1'b1; a = 32'd100; b = 32'd1; op = 2'd1;
         end else begin
            start = 1'b0;
         end
      end
      $display("op=%0d a=%h b=%h -> result=%h done_edge=%0d dones=%0d",
               o, x, y, res, lat, ndone);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
      else pass_cnt++;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done);
      else pass_cnt++;
      total_cnt++;
      if (result !== '0) $display("FAIL reset_result: got %h want 0", result);
      else pass_cnt++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy);
      else pass_cnt++;
      $display("reset: busy=%b done=%b result=%h", busy, done, result);
   endtask

   task automatic test_vectors();
      logic [W-1:0] res;
      int lat, nd;
      vecs = '{
         '{2'd0, 32'd20,        32'd3,        32'd6,        33},
         '{2'd2, 32'd20,        32'd3,        32'd2,        33},
         '{2'd0, 32'hFFFFFFEC,  32'd3,        32'hFFFFFFFA, 33},
         '{2'd2, 32'hFFFFFFEC,  32'd3,        32'hFFFFFFFE, 33},
         '{2'd3, 32'hFFFFFFEC,  32'd3,        32'h00000002, 33},
         '{2'd1, 32'hFFFFFFFF,  32'd2,        32'h7FFFFFFF, 33},
         '{2'd0, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 33},
         '{2'd2, 32'd7,         32'hFFFFFFFE, 32'd1,        33},
         '{2'd0, 32'd7,         32'd0,        32'hFFFFFFFF, 1},
         '{2'd2, 32'd7,         32'd0,        32'd7,        1},
         '{2'd1, 32'd7,         32'd0,        32'hFFFFFFFF, 1},
         '{2'd0, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1},
         '{2'd2, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1},
         '{2'd1, 32'h80000000,  32'hFFFFFFFF, 32'd0,        33}
      };
      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i].o, vecs[i].x, vecs[i].y, 0, res, lat, nd);
         total_cnt++;
         if (res !== vecs[i].exp)
            $display("FAIL vec%0d_result: got %h want %h", i, res, vecs[i].exp);
         else pass_cnt++;
         total_cnt++;
         if (lat != vecs[i].lat)
            $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, vecs[i].lat);
         else pass_cnt++;
         total_cnt++;
         if (nd != 1)
            $display("FAIL vec%0d_done_count: got %0d want 1", i, nd);
         else pass_cnt++;
      end
   endtask

   task automatic test_ignore_start();
      logic [W-1:0] res;
      int lat, nd;
      run_op(2'd0, 32'd20, 32'd3, 5, res, lat, nd);
      total_cnt++;
      if (res !== 32'd6) $display("FAIL ignore_result: got %h want 6", res);
      else pass_cnt++;
      total_cnt++;
      if (lat != 33) $display("FAIL ignore_latency: got %0d want 33", lat);
      else pass_cnt++;
      total_cnt++;
      if (nd != 1) $display("FAIL ignore_done_count: got %0d want 1", nd);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] res;
      int lat, nd;
      @(negedge clk);
      op = 2'd0; a = 32'd20; b = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy);
      else pass_cnt++;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy);
      else pass_cnt++;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done);
      else pass_cnt++;
      total_cnt++;
      if (result !== '0) $display("FAIL midrst_result: got %h want 0", result);
      else pass_cnt++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) nd++;
      end
      total_cnt++;
      if (nd != 0) $display("FAIL midrst_stray_done: got %0d want 0", nd);
      else pass_cnt++;
      $display("mid-calc reset: stray dones=%0d", nd);
      run_op(2'd0, 32'd9, 32'd3, 0, res, lat, nd);
      total_cnt++;
      if (res !== 32'd3) $display("FAIL midrst_after_result: got %h want 3", res);
      else pass_cnt++;
      total_cnt++;
      if (lat != 33) $display("FAIL midrst_after_latency: got %0d want 33", lat);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] res1, res2;
      int lat1, lat2;
      lat1 = -1; lat2 = -1; res1 = '0; res2 = '0;
      @(negedge clk);
      op = 2'd0; a = 32'd20; b = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            lat1 = k;
            res1 = result;
            break;
         end
      end
      total_cnt++;
      if (lat1 != 33) $display("FAIL b2b_first_latency: got %0d want 33", lat1);
      else pass_cnt++;
      total_cnt++;
      if (res1 !== 32'd6) $display("FAIL b2b_first_result: got %h want 6", res1);
      else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL b2b_busy_in_done: got %b want 0", busy);
      else pass_cnt++;
      // Start held high during the done cycle
      op = 2'd0; a = 32'd9; b = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL b2b_accept_busy: got %b want 1", busy);
      else pass_cnt++;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL b2b_done_pulse: got %b want 0", done);
      else pass_cnt++;
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            lat2 = k;
            res2 = result;
            break;
         end
      end
      total_cnt++;
      if (lat2 != 33) $display("FAIL b2b_second_latency: got %0d want 33", lat2);
      else pass_cnt++;
      total_cnt++;
      if (res2 !== 32'd3) $display("FAIL b2b_second_result: got %h want 3", res2);
      else pass_cnt++;
      $display("back-to-back: first=%h@%0d second=%h@%0d", res1, lat1, res2, lat2);
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish, got hang want completion");
      $fatal(1, "timeout");
   end

endmodule
